// File: rtl/fetch_unit.sv
// Purpose: instruction fetch with PC register, 2-entry {pc, instr} buffer and redirect handling.
// Latency: instruction at o_imem_add appears at the buffer head one cycle later; 1 instr/cycle sustained.
// Backpressure: o_valid/i_ready handshake; fetch stalls (PC parks) when the buffer is full and not popping.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_imem_add,
    input  logic [31:0] i_imem_instr,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_misalign
);

    logic [31:0] pc_q, pc_d;
    logic [1:0]  occ_q, occ_d;
    logic        misalign_q, misalign_d;

    // Slot 0 is always the oldest entry; slot 1 only holds data when FULL.
    logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;
    logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;

    logic pop;
    logic push;
    logic wr_hi;

    assign o_valid    = (occ_q != 2'd0);
    assign pop        = o_valid && i_ready;
    assign push       = !i_redirect && ((occ_q != 2'd2) || pop);
    // After an optional pop-shift, the new entry lands in the first free slot.
    assign wr_hi      = (occ_q == 2'd2) || ((occ_q == 2'd1) && !pop);

    assign o_imem_add = pc_q;
    assign o_instr    = ins0_q;
    assign o_pc       = pc0_q;
    assign o_pc_plus4 = pc0_q + 32'd4;
    assign o_misalign = misalign_q;

    // Control next state: redirect wins, otherwise occupancy follows push/pop.
    always_comb begin
        pc_d       = pc_q;
        occ_d      = occ_q;
        misalign_d = misalign_q;
        if (i_redirect) begin
            occ_d      = 2'd0;
            pc_d       = {i_redirect_pc[31:2], 2'b00};
            misalign_d = |i_redirect_pc[1:0];
        end else begin
            if (push) begin
                pc_d = pc_q + 32'd4;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Buffer data next state: shift on pop, then write the fetched word into the free slot.
    always_comb begin
        pc0_d  = pc0_q;
        ins0_d = ins0_q;
        pc1_d  = pc1_q;
        ins1_d = ins1_q;
        if (pop) begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
        end
        if (push) begin
            if (wr_hi) begin
                pc1_d  = pc_q;
                ins1_d = i_imem_instr;
            end else begin
                pc0_d  = pc_q;
                ins0_d = i_imem_instr;
            end
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q       <= RESET_PC;
            occ_q      <= 2'd0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            occ_q      <= occ_d;
            misalign_q <= misalign_d;
        end
    end

    // Buffer payload needs no reset; it is only observed while o_valid is high.
    always_ff @(posedge i_clk) begin
        pc0_q  <= pc0_d;
        ins0_q <= ins0_d;
        pc1_q  <= pc1_d;
        ins1_q <= ins1_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: scoreboard bench for fetch_unit; directed phases push expected PCs, a monitor checks handshakes.
// Latency: memory model returns data = address combinationally.
// Backpressure: i_ready driven per phase; monitor only consumes on accepted handshakes.
module tb_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic [31:0] o_imem_add;
    logic [31:0] i_imem_instr;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        o_misalign;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_imem_add    (o_imem_add),
        .i_imem_instr  (i_imem_instr),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_pc_plus4    (o_pc_plus4),
        .o_misalign    (o_misalign)
    );

    // Instruction memory: word content equals its address.
    assign i_imem_instr = o_imem_add;

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Assert reset between edges, verify async effect, release one edge later.
    task automatic do_reset();
        i_rst_n = 1'b0;
        #2;
        check("rst_valid",    {31'd0, o_valid},    32'd0);
        check("rst_imem_add", o_imem_add,          32'h0);
        check("rst_misalign", {31'd0, o_misalign}, 32'd0);
        tick();
        i_rst_n = 1'b1;
    endtask

    // Monitor: every accepted head entry must match the next expected PC.
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready && !i_redirect) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_extra: got pc %h expected no output", o_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("mon_pc",     o_pc,       e);
                check("mon_instr",  o_instr,    e);
                check("mon_plus4",  o_pc_plus4, e + 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick();

        // Streaming from reset with decode always ready.
        i_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        ticks(9);
        i_ready = 1'b0;

        // Backpressure: fill, park, then drain without gaps.
        do_reset();
        ticks(5);
        check("park_valid", {31'd0, o_valid}, 32'd1);
        check("park_add",   o_imem_add,       32'h8);
        check("park_pc",    o_pc,             32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        i_ready = 1'b1;
        ticks(4);

        // Redirect while full with decode ready.
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        tick();
        i_redirect = 1'b0;
        check("redir_valid0", {31'd0, o_valid}, 32'd0);
        check("redir_add",    o_imem_add,       32'h100);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        tick();
        check("redir_valid1", {31'd0, o_valid}, 32'd1);
        check("redir_pc",     o_pc,             32'h100);
        ticks(2);

        // Misaligned redirect then aligned redirect.
        i_ready       = 1'b0;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h102;
        tick();
        i_redirect = 1'b0;
        check("mis_flag",  {31'd0, o_misalign}, 32'd1);
        check("mis_add",   o_imem_add,          32'h100);
        tick();
        check("mis_pc",    o_pc,                32'h100);
        check("mis_hold",  {31'd0, o_misalign}, 32'd1);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h200;
        tick();
        i_redirect = 1'b0;
        check("mis_clear", {31'd0, o_misalign}, 32'd0);
        check("mis_add2",  o_imem_add,          32'h200);

        // Wrap at the top of the address space.
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        tick();
        i_redirect = 1'b0;
        check("wrap_add0", o_imem_add, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc",    o_pc,       32'hFFFF_FFFC);
        check("wrap_plus4", o_pc_plus4, 32'h0);
        check("wrap_add1",  o_imem_add, 32'h0);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        i_ready = 1'b1;
        ticks(3);

        // Mid-stream reset clears misalign and restarts at RESET_PC.
        i_ready       = 1'b0;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h306;
        tick();
        i_redirect = 1'b0;
        tick();
        check("pre_rst_mis", {31'd0, o_misalign}, 32'd1);
        check("pre_rst_pc",  o_pc,                32'h304);
        i_ready = 1'b1;
        do_reset();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        ticks(4);
        i_ready = 1'b0;
        tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: o_imem_add  output  32  byte address to instr_mem i_add.
REQ-005 SHALL have port: i_imem_instr  input  32  instr_mem o_instr, combinational read of o_imem_add in the same cycle.
REQ-006 SHALL have port: i_redirect  input  1  branch/jump taken; load new PC.
REQ-007 SHALL have port: i_redirect_pc  input  32  redirect target byte address.
REQ-008 SHALL have port: o_valid  output  1  head entry valid toward decode.
REQ-009 SHALL have port: i_ready  input  1  decode accepts head entry.
REQ-010 SHALL have port: o_instr  output  32  head instruction.
REQ-011 SHALL have port: o_pc  output  32  head PC.
REQ-012 SHALL have port: o_pc_plus4  output  32  o_pc + 4, modulo 2^32.
REQ-013 SHALL have port: o_misalign  output  1  last redirect target had bits [1:0] != 0.

Function
REQ-014 SHALL hold a PC register and drive o_imem_add = PC combinationally, stable while no push occurs.
REQ-015 SHALL hold a 2-entry in-order buffer of {pc, instr} with occupancy states EMPTY(0), ONE(1), FULL(2).
REQ-016 pop = o_valid && i_ready; o_valid = (occupancy != 0); o_instr/o_pc show the oldest entry.
REQ-017 push = !i_redirect && (occupancy < 2 || pop); push writes {PC, i_imem_instr} and sets PC <= PC + 4.
REQ-018 Transitions: push && !pop raises occupancy by 1; pop && !push lowers it by 1; push && pop keeps it unchanged; a simultaneous push and pop in FULL SHALL neither lose nor duplicate entries.
REQ-019 PC increment SHALL wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-020 i_redirect SHALL take priority over everything else:
- occupancy <= 0 at the next edge (all entries discarded, including any head popped that cycle).
- PC <= {i_redirect_pc[31:2], 2'b00}.
- No push that cycle.
REQ-021 On i_redirect, o_misalign SHALL register |i_redirect_pc[1:0] and hold that value until the next redirect.
REQ-022 Latency: the instruction at address A SHALL appear on o_instr/o_pc one cycle after o_imem_add = A; sustained throughput with i_ready = 1 SHALL be one instruction per cycle.
REQ-023 While o_valid = 1 and i_ready = 0, o_instr/o_pc SHALL remain stable.
REQ-024 i_ready SHALL be ignored while o_valid = 0.

Reset
REQ-025 On assertion of i_rst_n = 0, asynchronously and immediately: PC = RESET_PC, occupancy = 0, o_valid = 0, o_misalign = 0, o_imem_add = RESET_PC.
REQ-026 Buffer data contents SHALL need no reset; o_instr/o_pc/o_pc_plus4 are don't-care while o_valid = 0.
REQ-027 The first push SHALL occur on the first rising edge with i_rst_n = 1; reset mid-stream SHALL discard all entries with no residual output.

Verification
REQ-028 Reset release, i_ready = 1, memory returns data = address -> o_valid = 1 from cycle 1; o_pc = 0, 4, 8, ... one per cycle; o_instr == o_pc; o_pc_plus4 == o_pc + 4.
REQ-029 i_ready = 0 for 5 cycles after start -> occupancy FULL, o_imem_add parked at 8, o_pc held at 0; on i_ready = 1 -> o_pc = 0, 4, 8, 12 with no gaps or duplicates.
REQ-030 i_redirect with i_redirect_pc = 0x100 while FULL and i_ready = 1 -> next cycle o_valid = 0 and o_imem_add = 0x100; following cycle o_valid = 1, o_pc = 0x100.
REQ-031 Redirect to 0x102 -> o_misalign = 1 and o_pc = 0x100; a later redirect to 0x200 -> o_misalign = 0.
REQ-032 Redirect to 0xFFFF_FFFC -> o_pc = 0xFFFF_FFFC with o_pc_plus4 = 0x0, then o_pc = 0x0.
REQ-033 i_rst_n driven low between clock edges mid-stream -> o_valid = 0 and o_imem_add = RESET_PC before the next edge; after release, fetch restarts at RESET_PC.
